sram_log_sequencer: RTL and testbench
=====================================

# sram_log_sequencer

Command-side client for the SRAM interface block. Buffers 16-bit samples from the telemetry path in a small FIFO and writes them to consecutive SRAM word locations through the interface's CMD/STATUS handshake. On request, optionally reads the logged words back out as a valid/ready stream for downlink. Sits between the sensor-packing logic and the SRAM interface, and drives that block's ADDRESS_IN, DATA_IN, CMD_IN and CHIP_SELECT.

## Interface
- FIFO_DEPTH, 4: sample FIFO entries, power of two, 2–16.
- TIMEOUT, 15: maximum cycles from ISSUE to STATUS returning low, 4–255.

Ports:
- CLK_48MHZ  in  1  system clock; every signal is synchronous to it.
- RESET  in  1  asynchronous, active-low reset.
- SAMPLE_DATA  in  16  sample word.
- SAMPLE_VALID  in  1  sample offered.
- SAMPLE_READY  out  1  transfer occurs on a clock edge when SAMPLE_VALID and SAMPLE_READY are both 1.
- LOG_CLEAR  in  1  one-cycle pulse; clears the log. Honoured only in IDLE when the FIFO is empty.
- DUMP_REQ  in  1  one-cycle pulse; starts a readback.
- DUMP_DATA  out  16  readback word.
- DUMP_VALID  out  1  readback word valid.
- DUMP_READY  in  1  readback consumer ready.
- DUMP_DONE  out  1  one-cycle pulse when the readback completes.
- ADDRESS_OUT  out  18  to the interface's ADDRESS_IN.
- DATA_OUT  out  16  to the interface's DATA_IN.
- CMD_OUT  out  2  to the interface's CMD_IN: 0 = none, 1 = read, 2 = write.
- CHIP_SELECT_OUT  out  1  to the interface's CHIP_SELECT; selects the lane pair.
- STATUS_IN  in  1  from the interface's STATUS (busy).
- DATA_READ_IN  in  16  from the interface's DATA_READ.
- WORD_COUNT  out  20  number of words logged, 0 to 524288.
- LOG_FULL  out  1  WORD_COUNT == 524288.
- OVERFLOW  out  1  sticky; a sample was discarded because the log was full.
- ERROR  out  1  sticky; a handshake timeout occurred.

## Operation
- Reset values: all outputs 0 except SAMPLE_READY = 1. FIFO is empty. Write pointer and WORD_COUNT are 0. State is IDLE.
- Word pointer wp is 19 bits. CHIP_SELECT_OUT = wp[18] and ADDRESS_OUT = wp[17:0]. Readback uses its own pointer rp with the same mapping.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, and, with readback, RD_OUT.
- IDLE transitions, in priority order:
  - FIFO not empty and not LOG_FULL: pop the FIFO into DATA_OUT, go to ISSUE with write.
  - A latched dump request: go to ISSUE with read at rp.
  - Otherwise stay in IDLE.
- ISSUE: CMD_OUT = 2 or 1 for exactly one cycle, then WAIT_HI. CMD_OUT is 0 in every other state.
- WAIT_HI: when STATUS_IN = 1, go to WAIT_LO.
- WAIT_LO: when STATUS_IN = 0:
  - After a write: wp and WORD_COUNT increment; go to IDLE.
  - After a read: capture DATA_READ_IN into DUMP_DATA, set DUMP_VALID, go to RD_OUT.
- RD_OUT: hold the word until DUMP_VALID && DUMP_READY. Then rp increments.
  - If rp reaches WORD_COUNT: pulse DUMP_DONE, clear the dump latch.
  - Go to IDLE.
- ADDRESS_OUT, DATA_OUT and CHIP_SELECT_OUT are stable from ISSUE until the return to IDLE.
- Timeout: a counter starts at ISSUE. If it reaches TIMEOUT before WAIT_LO completes:
  - set ERROR and force CMD_OUT to 0;
  - do not advance the pointer (a failed write stays unlogged);
  - go to IDLE. A dump in progress is aborted with DUMP_DONE.
- SAMPLE_READY:
  - While not LOG_FULL: SAMPLE_READY = !FIFO full.
  - While LOG_FULL: SAMPLE_READY = 1, accepted samples are discarded, and OVERFLOW is set.
- Simultaneous FIFO push and pop on the same edge is allowed; occupancy is unchanged.
- DUMP_REQ:
  - Ignored while a dump is active.
  - Latched otherwise, with rp cleared to 0.
  - With WORD_COUNT = 0: DUMP_DONE is pulsed the next cycle and no read is issued.
  - While a dump is active, FIFO drain has priority at each IDLE visit, so reads and writes interleave.
- LOG_CLEAR: clears wp, WORD_COUNT, LOG_FULL and OVERFLOW. ERROR is cleared only by reset.
- RESET asserted mid-cycle: everything returns to reset values immediately, so CMD_OUT drops to 0. The in-flight SRAM word is undefined.

## Timing
- Write: ISSUE, WAIT_HI, WAIT_LO, IDLE. Sustained throughput is one word per 4 cycles.
- Sample to CMD_OUT = 2: the sample is accepted at edge N, the FIFO becomes non-empty after N, IDLE pops at N+1, and CMD_OUT = 2 during the cycle after N+1. Minimum latency is 2 cycles.
- Read: DUMP_VALID rises 4 cycles after ISSUE, because the interface keeps STATUS high for 2 cycles on a read.
- CMD_OUT is never 1 or 2 on two consecutive cycles. This guarantees the interface cannot re-trigger on the edge where STATUS falls.

## Configuration
- SRAM_LOG_READBACK_EN:
  - Defined: the dump path, rp and RD_OUT are built.
  - Undefined: DUMP_REQ is ignored; DUMP_DATA, DUMP_VALID and DUMP_DONE are tied to 0; CMD_OUT never equals 1.

## Test plan
- Reset, then write 3 samples 0x1111, 0x2222, 0x3333. Expect 3 CMD_OUT = 2 pulses at addresses 0, 1, 2, 4 cycles apart, and WORD_COUNT = 3.
- Offer a sample every cycle for 20 cycles. Expect SAMPLE_READY low whenever the FIFO is full, no samples lost, and WORD_COUNT = 20.
- Preload WORD_COUNT = 524287, then send 2 samples. Expect the first written at CHIP_SELECT_OUT = 1, ADDRESS_OUT = 0x3FFFF; then LOG_FULL = 1 and OVERFLOW = 1.
- With 3 words logged, pulse DUMP_REQ while the SRAM model returns address + 0xA000, holding DUMP_READY low for 5 cycles on word 1. Expect DUMP_DATA 0xA000, 0xA001, 0xA002 in order, then one DUMP_DONE pulse.
- STATUS_IN held at 0 after ISSUE. Expect ERROR = 1 after TIMEOUT cycles, WORD_COUNT unchanged, and a return to IDLE.
- Assert RESET during WAIT_HI of a write. Expect CMD_OUT = 0, WORD_COUNT = 0, and SAMPLE_READY = 1 immediately.

Source files
------------

// File: rtl/sram_log_sequencer.sv
// sram_log_sequencer: buffers telemetry samples in a small FIFO and logs
// them to consecutive SRAM words over the interface CMD/STATUS handshake.
// Optional readback (`SRAM_LOG_READBACK_EN) streams the log out again.
// Ports: CLK_48MHZ/RESET (async, active low); SAMPLE_* valid/ready input;
// LOG_CLEAR, DUMP_REQ pulses; DUMP_* readback stream; ADDRESS_OUT,
// DATA_OUT, CMD_OUT, CHIP_SELECT_OUT, STATUS_IN, DATA_READ_IN to the SRAM
// interface; WORD_COUNT, LOG_FULL, OVERFLOW, ERROR status.
module sram_log_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET,
    input  logic [15:0] SAMPLE_DATA,
    input  logic        SAMPLE_VALID,
    output logic        SAMPLE_READY,
    input  logic        LOG_CLEAR,
    input  logic        DUMP_REQ,
    output logic [15:0] DUMP_DATA,
    output logic        DUMP_VALID,
    input  logic        DUMP_READY,
    output logic        DUMP_DONE,
    output logic [17:0] ADDRESS_OUT,
    output logic [15:0] DATA_OUT,
    output logic [1:0]  CMD_OUT,
    output logic        CHIP_SELECT_OUT,
    input  logic        STATUS_IN,
    input  logic [15:0] DATA_READ_IN,
    output logic [19:0] WORD_COUNT,
    output logic        LOG_FULL,
    output logic        OVERFLOW,
    output logic        ERROR
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_HI, WAIT_LO, RD_OUT
    } state_t;

    state_t state, state_nx;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ;
    // cnt doubles as the write pointer: wp = cnt[18:0], cnt[19] = full
    logic [19:0]   cnt;
    logic [18:0]   rp, addr_q;
    logic [15:0]   data_q;
    logic [7:0]    tmo;
    logic          is_wr, ovf_q, err_q, dump_act;
    logic          fifo_empty, fifo_full, log_full, push, clear;
    logic          pop, discard, go_wr, go_rd, wr_done;
    logic          rd_cap, rd_acc, tmo_hit, tmo_now;

    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == (AW+1)'(FIFO_DEPTH));
    assign log_full   = cnt[19];
    assign push       = SAMPLE_VALID && !log_full && !fifo_full;
    assign clear      = LOG_CLEAR && (state == IDLE) && fifo_empty;
    assign tmo_now    = (tmo == 8'(TIMEOUT));

    assign SAMPLE_READY    = log_full || !fifo_full;
    assign ADDRESS_OUT     = addr_q[17:0];
    assign CHIP_SELECT_OUT = addr_q[18];
    assign DATA_OUT        = data_q;
    assign WORD_COUNT      = cnt;
    assign LOG_FULL        = log_full;
    assign OVERFLOW        = ovf_q;
    assign ERROR           = err_q;

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        discard  = 1'b0;
        go_wr    = 1'b0;
        go_rd    = 1'b0;
        wr_done  = 1'b0;
        rd_cap   = 1'b0;
        rd_acc   = 1'b0;
        tmo_hit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && !log_full) begin
                    pop      = 1'b1;
                    go_wr    = 1'b1;
                    state_nx = ISSUE;
                end else begin
                    // entries stranded by a full log are dropped
                    discard = !fifo_empty;
                    if (dump_act) begin
                        go_rd    = 1'b1;
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: state_nx = WAIT_HI;
            WAIT_HI: begin
                if (STATUS_IN) begin
                    state_nx = WAIT_LO;
                end else if (tmo_now) begin
                    tmo_hit  = 1'b1;
                    state_nx = IDLE;
                end
            end
            WAIT_LO: begin
                if (!STATUS_IN) begin
                    wr_done  = is_wr;
                    rd_cap   = !is_wr;
                    state_nx = is_wr ? IDLE : RD_OUT;
                end else if (tmo_now) begin
                    tmo_hit  = 1'b1;
                    state_nx = IDLE;
                end
            end
            RD_OUT: begin
                if (DUMP_READY) begin
                    rd_acc   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK_48MHZ) begin
        if (push) mem[wr_ptr] <= SAMPLE_DATA;
    end

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            tmo    <= '0;
            is_wr  <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop || discard) rd_ptr <= rd_ptr + 1'b1;
            if (pop) data_q <= mem[rd_ptr];
            case ({push, pop || discard})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (go_wr || go_rd) tmo <= 8'd1;
            else if (state != IDLE && state != RD_OUT) tmo <= tmo + 1'b1;
            if (go_wr) begin
                is_wr  <= 1'b1;
                addr_q <= cnt[18:0];
            end
            if (go_rd) begin
                is_wr  <= 1'b0;
                addr_q <= rp;
            end
            if (wr_done) cnt <= cnt + 1'b1;
            if (clear) begin
                cnt   <= '0;
                ovf_q <= 1'b0;
            end
            if ((SAMPLE_VALID && log_full) || discard) ovf_q <= 1'b1;
            if (tmo_hit) err_q <= 1'b1;
        end
    end

`ifdef SRAM_LOG_READBACK_EN
    logic [15:0] ddata_q;
    logic        dvalid_q, done_q;

    assign CMD_OUT    = (state == ISSUE) ? (is_wr ? 2'd2 : 2'd1) : 2'd0;
    assign DUMP_DATA  = ddata_q;
    assign DUMP_VALID = dvalid_q;
    assign DUMP_DONE  = done_q;

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            dump_act <= 1'b0;
            rp       <= '0;
            ddata_q  <= '0;
            dvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (DUMP_REQ && !dump_act) begin
                if (cnt == '0) begin
                    done_q <= 1'b1;
                end else begin
                    dump_act <= 1'b1;
                    rp       <= '0;
                end
            end
            if (rd_cap) begin
                ddata_q  <= DATA_READ_IN;
                dvalid_q <= 1'b1;
            end
            if (rd_acc) begin
                dvalid_q <= 1'b0;
                rp       <= rp + 1'b1;
                // cnt may have grown from interleaved writes
                if ({1'b0, rp} + 20'd1 == cnt) begin
                    done_q   <= 1'b1;
                    dump_act <= 1'b0;
                end
            end
            if (tmo_hit && dump_act) begin
                done_q   <= 1'b1;
                dump_act <= 1'b0;
            end
            if (clear) dump_act <= 1'b0;
        end
    end
`else
    logic unused_rb;

    assign unused_rb  = ^{DUMP_REQ, DATA_READ_IN};
    assign dump_act   = 1'b0;
    assign rp         = '0;
    assign CMD_OUT    = (state == ISSUE) ? 2'd2 : 2'd0;
    assign DUMP_DATA  = '0;
    assign DUMP_VALID = 1'b0;
    assign DUMP_DONE  = 1'b0;
`endif

endmodule

// File: tb/tb_sram_log_sequencer.sv
// tb_sram_log_sequencer: directed bench for sram_log_sequencer with a
// small SRAM-interface model and a CMD_OUT event monitor.
module tb_sram_log_sequencer;

    localparam int TMO = 15;

    logic        CLK_48MHZ = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] SAMPLE_DATA = '0;
    logic        SAMPLE_VALID = 1'b0;
    logic        SAMPLE_READY;
    logic        LOG_CLEAR = 1'b0;
    logic        DUMP_REQ = 1'b0;
    logic [15:0] DUMP_DATA;
    logic        DUMP_VALID;
    logic        DUMP_READY = 1'b1;
    logic        DUMP_DONE;
    logic [17:0] ADDRESS_OUT;
    logic [15:0] DATA_OUT;
    logic [1:0]  CMD_OUT;
    logic        CHIP_SELECT_OUT;
    logic        STATUS_IN;
    logic [15:0] DATA_READ_IN;
    logic [19:0] WORD_COUNT;
    logic        LOG_FULL;
    logic        OVERFLOW;
    logic        ERROR;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic sram_en = 1'b1;
    logic [1:0] left;

    typedef struct {
        int          cyc;
        logic [1:0]  cmd;
        logic        cs;
        logic [17:0] a;
        logic [15:0] d;
    } ev_t;

    ev_t evq[$];
    logic [1:0] prev_cmd = 2'd0;
    int b2b = 0;

    always #5 CLK_48MHZ = ~CLK_48MHZ;

    sram_log_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
        .CLK_48MHZ(CLK_48MHZ), .RESET(RESET),
        .SAMPLE_DATA(SAMPLE_DATA), .SAMPLE_VALID(SAMPLE_VALID),
        .SAMPLE_READY(SAMPLE_READY), .LOG_CLEAR(LOG_CLEAR),
        .DUMP_REQ(DUMP_REQ), .DUMP_DATA(DUMP_DATA),
        .DUMP_VALID(DUMP_VALID), .DUMP_READY(DUMP_READY),
        .DUMP_DONE(DUMP_DONE), .ADDRESS_OUT(ADDRESS_OUT),
        .DATA_OUT(DATA_OUT), .CMD_OUT(CMD_OUT),
        .CHIP_SELECT_OUT(CHIP_SELECT_OUT), .STATUS_IN(STATUS_IN),
        .DATA_READ_IN(DATA_READ_IN), .WORD_COUNT(WORD_COUNT),
        .LOG_FULL(LOG_FULL), .OVERFLOW(OVERFLOW), .ERROR(ERROR)
    );

    always @(posedge CLK_48MHZ) cyc <= cyc + 1;

    // busy 1 cycle for a write, 2 for a read; read data = address + 0xA000
    always @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            STATUS_IN    <= 1'b0;
            left         <= 2'd0;
            DATA_READ_IN <= '0;
        end else if (sram_en && CMD_OUT != 2'd0) begin
            STATUS_IN    <= 1'b1;
            left         <= (CMD_OUT == 2'd1) ? 2'd1 : 2'd0;
            DATA_READ_IN <= ADDRESS_OUT[15:0] + 16'hA000;
        end else if (left != 2'd0) begin
            left <= left - 2'd1;
        end else begin
            STATUS_IN <= 1'b0;
        end
    end

    always @(negedge CLK_48MHZ) begin
        if (CMD_OUT != 2'd0 && prev_cmd != 2'd0) b2b++;
        if (CMD_OUT != 2'd0)
            evq.push_back('{cyc, CMD_OUT, CHIP_SELECT_OUT,
                            ADDRESS_OUT, DATA_OUT});
        prev_cmd = CMD_OUT;
    end

    task automatic send(input logic [15:0] d, output int acc);
        int n = 0;
        SAMPLE_DATA  = d;
        SAMPLE_VALID = 1'b1;
        while (!SAMPLE_READY && n < 100) begin
            @(negedge CLK_48MHZ);
            n++;
        end
        acc = cyc;
        @(negedge CLK_48MHZ);
        SAMPLE_VALID = 1'b0;
    endtask

    task automatic wait_words(input logic [19:0] w);
        for (int n = 0; n < 300 && WORD_COUNT != w; n++)
            @(negedge CLK_48MHZ);
        repeat (4) @(negedge CLK_48MHZ);
    endtask

    task automatic pulse_clear();
        LOG_CLEAR = 1'b1;
        @(negedge CLK_48MHZ);
        LOG_CLEAR = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK_48MHZ);
        RESET = 1'b1;
        @(negedge CLK_48MHZ);
        n_chk++;
        if (SAMPLE_READY !== 1'b1)
            $display("FAIL rst_ready: got %0h want 1", SAMPLE_READY);
        else n_pass++;
        n_chk++;
        if ({CMD_OUT, WORD_COUNT, LOG_FULL, OVERFLOW, ERROR} !== '0)
            $display("FAIL rst_status: got %0h want 0",
                     {CMD_OUT, WORD_COUNT, LOG_FULL, OVERFLOW, ERROR});
        else n_pass++;
        n_chk++;
        if ({ADDRESS_OUT, CHIP_SELECT_OUT, DATA_OUT,
             DUMP_VALID, DUMP_DONE, DUMP_DATA} !== '0)
            $display("FAIL rst_bus: got %0h want 0",
                     {ADDRESS_OUT, CHIP_SELECT_OUT, DATA_OUT});
        else n_pass++;
    endtask

    task automatic test_write3();
        int base = evq.size();
        int acc0, acc;
        logic [15:0] want [3];
        want[0] = 16'h1111;
        want[1] = 16'h2222;
        want[2] = 16'h3333;
        send(want[0], acc0);
        send(want[1], acc);
        send(want[2], acc);
        wait_words(20'd3);
        n_chk++;
        if (WORD_COUNT !== 20'd3)
            $display("FAIL w3_count: got %0d want 3", WORD_COUNT);
        else n_pass++;
        n_chk++;
        if (evq.size() - base !== 3)
            $display("FAIL w3_pulses: got %0d want 3", evq.size() - base);
        else n_pass++;
        if (evq.size() - base >= 3) begin
            n_chk++;
            if (evq[base].cyc !== acc0 + 2)
                $display("FAIL w3_latency: got %0d want %0d",
                         evq[base].cyc - acc0, 2);
            else n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if ({evq[base+i].cmd, evq[base+i].cs, evq[base+i].a,
                     evq[base+i].d} !== {2'd2, 1'b0, 18'(i), want[i]})
                    $display("FAIL w3_word%0d: got a=%0h d=%0h want a=%0h d=%0h",
                             i, evq[base+i].a, evq[base+i].d, i, want[i]);
                else n_pass++;
            end
            n_chk++;
            if (evq[base+2].cyc - evq[base+1].cyc !== 4)
                $display("FAIL w3_spacing: got %0d want 4",
                         evq[base+2].cyc - evq[base+1].cyc);
            else n_pass++;
        end
    endtask

    task automatic test_stream20();
        int base, i, low;
        pulse_clear();
        n_chk++;
        if (WORD_COUNT !== 20'd0)
            $display("FAIL clr_count: got %0d want 0", WORD_COUNT);
        else n_pass++;
        base = evq.size();
        i = 0;
        low = 0;
        SAMPLE_VALID = 1'b1;
        for (int k = 0; k < 500 && i < 20; k++) begin
            SAMPLE_DATA = 16'h0100 + 16'(i);
            if (SAMPLE_READY) i++;
            else low++;
            @(negedge CLK_48MHZ);
        end
        SAMPLE_VALID = 1'b0;
        wait_words(20'd20);
        n_chk++;
        if (WORD_COUNT !== 20'd20)
            $display("FAIL s20_count: got %0d want 20", WORD_COUNT);
        else n_pass++;
        n_chk++;
        if (low == 0)
            $display("FAIL s20_backpressure: got %0d stalls want >0", low);
        else n_pass++;
        n_chk++;
        if (evq.size() - base !== 20)
            $display("FAIL s20_pulses: got %0d want 20", evq.size() - base);
        else n_pass++;
        for (int j = 0; j < 20 && base + j < evq.size(); j++) begin
            n_chk++;
            if ({evq[base+j].a, evq[base+j].d} !==
                {18'(j), 16'h0100 + 16'(j)})
                $display("FAIL s20_word%0d: got a=%0h d=%0h want a=%0h d=%0h",
                         j, evq[base+j].a, evq[base+j].d, j, 16'h0100 + j);
            else n_pass++;
        end
    endtask

    task automatic test_full();
        int base, acc;
        pulse_clear();
        dut.cnt = 20'd524287;
        base = evq.size();
        send(16'hBEEF, acc);
        send(16'hCAFE, acc);
        wait_words(20'h80000);
        repeat (6) @(negedge CLK_48MHZ);
        n_chk++;
        if (evq.size() - base !== 1)
            $display("FAIL full_pulses: got %0d want 1", evq.size() - base);
        else n_pass++;
        if (evq.size() > base) begin
            n_chk++;
            if ({evq[base].cs, evq[base].a, evq[base].d} !==
                {1'b1, 18'h3FFFF, 16'hBEEF})
                $display("FAIL full_last: got cs=%0h a=%0h d=%0h want 1 3ffff beef",
                         evq[base].cs, evq[base].a, evq[base].d);
            else n_pass++;
        end
        n_chk++;
        if ({WORD_COUNT, LOG_FULL, OVERFLOW, SAMPLE_READY} !==
            {20'h80000, 1'b1, 1'b1, 1'b1})
            $display("FAIL full_flags: got wc=%0h f=%0h o=%0h r=%0h want 80000 1 1 1",
                     WORD_COUNT, LOG_FULL, OVERFLOW, SAMPLE_READY);
        else n_pass++;
        pulse_clear();
        n_chk++;
        if ({WORD_COUNT, LOG_FULL, OVERFLOW} !== '0)
            $display("FAIL full_clear: got wc=%0h f=%0h o=%0h want 0",
                     WORD_COUNT, LOG_FULL, OVERFLOW);
        else n_pass++;
    endtask

`ifdef SRAM_LOG_READBACK_EN
    task automatic test_dump();
        int base, acc, got, dn, stall, bad, rds;
        logic [15:0] w [3];
        DUMP_REQ = 1'b1;
        @(negedge CLK_48MHZ);
        DUMP_REQ = 1'b0;
        n_chk++;
        if (DUMP_DONE !== 1'b1)
            $display("FAIL dump_empty_done: got %0h want 1", DUMP_DONE);
        else n_pass++;
        send(16'h5550, acc);
        send(16'h5551, acc);
        send(16'h5552, acc);
        wait_words(20'd3);
        base = evq.size();
        got = 0;
        dn = 0;
        stall = 0;
        bad = 0;
        DUMP_REQ = 1'b1;
        for (int k = 0; k < 150; k++) begin
            @(negedge CLK_48MHZ);
            DUMP_REQ = 1'b0;
            if (DUMP_DONE) dn++;
            if (got == 1 && DUMP_VALID && stall < 5) begin
                DUMP_READY = 1'b0;
                stall++;
                if (DUMP_DATA !== 16'hA001) bad++;
            end else begin
                DUMP_READY = 1'b1;
            end
            if (DUMP_VALID && DUMP_READY) begin
                if (got < 3) w[got] = DUMP_DATA;
                got++;
            end
        end
        n_chk++;
        if (got !== 3) $display("FAIL dump_count: got %0d want 3", got);
        else n_pass++;
        for (int i = 0; i < 3 && i < got; i++) begin
            n_chk++;
            if (w[i] !== 16'hA000 + 16'(i))
                $display("FAIL dump_word%0d: got %0h want %0h",
                         i, w[i], 16'hA000 + i);
            else n_pass++;
        end
        n_chk++;
        if ({stall, bad} !== {32'd5, 32'd0})
            $display("FAIL dump_stall: got stall=%0d bad=%0d want 5 0", stall, bad);
        else n_pass++;
        n_chk++;
        if (dn !== 1) $display("FAIL dump_done: got %0d want 1", dn);
        else n_pass++;
        rds = 0;
        for (int i = base; i < evq.size(); i++)
            if (evq[i].cmd == 2'd1 && evq[i].a == 18'(rds)) rds++;
        n_chk++;
        if (rds !== 3) $display("FAIL dump_reads: got %0d want 3", rds);
        else n_pass++;
    endtask
`else
    task automatic test_dump();
        int base, acc, seen;
        send(16'h5550, acc);
        wait_words(20'd1);
        base = evq.size();
        seen = 0;
        DUMP_REQ = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLK_48MHZ);
            DUMP_REQ = 1'b0;
            if (DUMP_VALID || DUMP_DONE) seen++;
        end
        n_chk++;
        if ({seen, evq.size() - base} !== '0)
            $display("FAIL norb_dump: got %0d %0d want 0 0",
                     seen, evq.size() - base);
        else n_pass++;
    endtask
`endif

    task automatic test_timeout();
        int acc, n, base;
        logic [19:0] wc0;
        logic found;
        wc0 = WORD_COUNT;
        sram_en = 1'b0;
        send(16'h7777, acc);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (CMD_OUT == 2'd2) found = 1'b1;
            else @(negedge CLK_48MHZ);
        end
        n = 0;
        while (!ERROR && n < 100) begin
            @(negedge CLK_48MHZ);
            n++;
        end
        n_chk++;
        if ({found, n} !== {1'b1, 32'(TMO)})
            $display("FAIL tmo_cycles: got found=%0d n=%0d want 1 %0d",
                     found, n, TMO);
        else n_pass++;
        n_chk++;
        if ({ERROR, WORD_COUNT} !== {1'b1, wc0})
            $display("FAIL tmo_state: got err=%0h wc=%0d want 1 %0d",
                     ERROR, WORD_COUNT, wc0);
        else n_pass++;
        sram_en = 1'b1;
        base = evq.size();
        send(16'h8888, acc);
        wait_words(wc0 + 20'd1);
        n_chk++;
        if (WORD_COUNT !== wc0 + 20'd1)
            $display("FAIL tmo_retry_count: got %0d want %0d",
                     WORD_COUNT, wc0 + 1);
        else n_pass++;
        if (evq.size() > base) begin
            n_chk++;
            if ({evq[base].a, evq[base].d} !== {wc0[17:0], 16'h8888})
                $display("FAIL tmo_retry_addr: got a=%0h d=%0h want %0h 8888",
                         evq[base].a, evq[base].d, wc0[17:0]);
            else n_pass++;
        end
        pulse_clear();
        n_chk++;
        if (ERROR !== 1'b1)
            $display("FAIL tmo_sticky: got %0h want 1", ERROR);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acc;
        send(16'h9999, acc);
        send(16'h9998, acc);
        wait_words(20'd2);
        send(16'h9997, acc);
        for (int k = 0; k < 20 && CMD_OUT != 2'd2; k++)
            @(negedge CLK_48MHZ);
        @(posedge CLK_48MHZ);
        #2;
        RESET = 1'b0;
        #1;
        n_chk++;
        if ({CMD_OUT, WORD_COUNT, ERROR} !== '0)
            $display("FAIL mid_rst: got cmd=%0h wc=%0d err=%0h want 0",
                     CMD_OUT, WORD_COUNT, ERROR);
        else n_pass++;
        n_chk++;
        if ({SAMPLE_READY, ADDRESS_OUT, DATA_OUT} !== {1'b1, 34'd0})
            $display("FAIL mid_rst_bus: got r=%0h a=%0h d=%0h want 1 0 0",
                     SAMPLE_READY, ADDRESS_OUT, DATA_OUT);
        else n_pass++;
        @(negedge CLK_48MHZ);
        RESET = 1'b1;
        repeat (8) @(negedge CLK_48MHZ);
        n_chk++;
        if ({CMD_OUT, WORD_COUNT} !== '0)
            $display("FAIL mid_rst_quiet: got cmd=%0h wc=%0d want 0",
                     CMD_OUT, WORD_COUNT);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write3();
        test_stream20();
        test_full();
        test_dump();
        test_timeout();
        test_reset_mid();
        n_chk++;
        if (b2b !== 0)
            $display("FAIL cmd_b2b: got %0d want 0", b2b);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
